// File: rtl/beam_threshold_loader_pkg.sv
// Shared beam constants and the threshold loader state encoding.
package beam_threshold_loader_pkg;

   localparam int unsigned NUM_BEAM = 48;
   localparam int unsigned DEF_TBITS = 18;
   localparam logic [DEF_TBITS-1:0] DEFAULT_THRESH = 18'd4000;

   typedef enum logic [2:0] {
      StIdle,
      StPrefetch,
      StShift,
      StUpdate,
      StDone
   } load_state_e;

endpackage

// File: rtl/threshold_shadow_ram.sv
// Simple dual-port shadow store: one write port, one read port with 1-cycle latency, no reset.
module threshold_shadow_ram #(
   parameter int unsigned DEPTH = 48,
   parameter int unsigned WIDTH = 36,
   parameter logic [WIDTH-1:0] INIT = '0,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Entries are stored XOR INIT so an all-zero power-up array reads back as INIT.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i ^ INIT;
      end
      rdata_q <= mem_q[raddr_i] ^ INIT;
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/beam_threshold_loader.sv
// Pushes the shadowed per-beam threshold pairs into the beamformer cascade, last beam first,
// then commits them with a single update strobe.
module beam_threshold_loader #(
   parameter int unsigned NBEAMS = beam_threshold_loader_pkg::NUM_BEAM,
   parameter int unsigned TBITS = beam_threshold_loader_pkg::DEF_TBITS,
   parameter logic [TBITS-1:0] DEFAULT_THRESH = TBITS'(beam_threshold_loader_pkg::DEFAULT_THRESH)
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic [7:0]         thr_addr_i,
   input  logic [2*TBITS-1:0] thr_dat_i,
   input  logic               thr_we_i,
   input  logic               load_req_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               wr_err_o,
   output logic [2*TBITS-1:0] thresh_o,
   output logic [1:0]         thresh_wr_o,
   output logic [1:0]         thresh_update_o
);

   import beam_threshold_loader_pkg::*;

   localparam int unsigned DW = 2 * TBITS;
   localparam int unsigned AW = $clog2(NBEAMS);
   localparam logic [AW-1:0] LAST_IDX = AW'(NBEAMS - 1);

   load_state_e   state_q;
   logic [AW-1:0] idx_q;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          pending_q;
   logic          busy_q;
   logic          done_q;
   logic          wr_err_q;
   logic [1:0]    thresh_wr_q;
   logic [1:0]    thresh_update_q;
   logic          addr_ok;
   logic          wr_en;

   assign addr_ok = 32'(thr_addr_i) < NBEAMS;
   // Writes are frozen during reset so the committed shadow survives an aborted load.
   assign wr_en   = rstn_i && thr_we_i && !busy_q && addr_ok;

   // Read one entry ahead of the one being shifted so the RAM latency is hidden.
   always_comb begin
      rd_addr = LAST_IDX;
      if (state_q == StShift && idx_q != '0) begin
         rd_addr = idx_q - 1'b1;
      end
   end

   threshold_shadow_ram #(
      .DEPTH (NBEAMS),
      .WIDTH (DW),
      .INIT  ({DEFAULT_THRESH, DEFAULT_THRESH})
   ) u_shadow (
      .clk_i   (clk_i),
      .we_i    (wr_en),
      .waddr_i (thr_addr_i[AW-1:0]),
      .wdata_i (thr_dat_i),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q         <= StIdle;
         idx_q           <= '0;
         pending_q       <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         wr_err_q        <= 1'b0;
         thresh_wr_q     <= 2'b00;
         thresh_update_q <= 2'b00;
      end else begin
         wr_err_q <= thr_we_i && (busy_q || !addr_ok);
         if (load_req_i && busy_q) begin
            pending_q <= 1'b1;
         end
         case (state_q)
            StIdle: begin
               if (load_req_i) begin
                  state_q <= StPrefetch;
                  busy_q  <= 1'b1;
                  idx_q   <= LAST_IDX;
               end
            end
            StPrefetch: begin
               state_q     <= StShift;
               thresh_wr_q <= 2'b11;
            end
            StShift: begin
               if (idx_q == '0) begin
                  state_q         <= StUpdate;
                  thresh_wr_q     <= 2'b00;
                  thresh_update_q <= 2'b11;
               end else begin
                  idx_q <= idx_q - 1'b1;
               end
            end
            StUpdate: begin
               state_q         <= StDone;
               thresh_update_q <= 2'b00;
               busy_q          <= 1'b0;
               done_q          <= 1'b1;
            end
            StDone: begin
               done_q    <= 1'b0;
               pending_q <= 1'b0;
               if (pending_q || load_req_i) begin
                  state_q <= StPrefetch;
                  busy_q  <= 1'b1;
                  idx_q   <= LAST_IDX;
               end else begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q         <= StIdle;
               busy_q          <= 1'b0;
               done_q          <= 1'b0;
               thresh_wr_q     <= 2'b00;
               thresh_update_q <= 2'b00;
            end
         endcase
      end
   end

   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign wr_err_o        = wr_err_q;
   assign thresh_wr_o     = thresh_wr_q;
   assign thresh_update_o = thresh_update_q;
   assign thresh_o        = thresh_wr_q[0] ? rd_data : '0;

endmodule

// File: tb/tb_beam_threshold_loader.sv
// Scoreboard bench for beam_threshold_loader: a cycle-level event model feeds queues that a
// negedge monitor drains against the DUT outputs.
module tb_beam_threshold_loader;

   localparam int unsigned N = 4;
   localparam int unsigned TB = 18;
   localparam int unsigned DW = 2 * TB;
   localparam logic [TB-1:0] DEF = 18'd4000;

   typedef struct {
      int            cyc;
      logic [DW-1:0] dat;
   } shift_t;

   logic          clk_i = 1'b0;
   logic          rstn_i;
   logic [7:0]    thr_addr_i;
   logic [DW-1:0] thr_dat_i;
   logic          thr_we_i;
   logic          load_req_i;
   logic          busy_o;
   logic          done_o;
   logic          wr_err_o;
   logic [DW-1:0] thresh_o;
   logic [1:0]    thresh_wr_o;
   logic [1:0]    thresh_update_o;

   beam_threshold_loader #(
      .NBEAMS         (N),
      .TBITS          (TB),
      .DEFAULT_THRESH (DEF)
   ) dut (
      .clk_i           (clk_i),
      .rstn_i          (rstn_i),
      .thr_addr_i      (thr_addr_i),
      .thr_dat_i       (thr_dat_i),
      .thr_we_i        (thr_we_i),
      .load_req_i      (load_req_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .wr_err_o        (wr_err_o),
      .thresh_o        (thresh_o),
      .thresh_wr_o     (thresh_wr_o),
      .thresh_update_o (thresh_update_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Reference model state
   shift_t        shift_q[$];
   int            upd_q[$];
   int            done_q[$];
   int            err_q[$];
   int            win_s[$];
   int            win_e[$];
   logic [DW-1:0] shadow[N];
   bit            pending = 1'b0;
   int            next_done = -1;

   int n_checks = 0;
   int n_pass = 0;
   bit mon_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
   endtask

   function automatic bit model_busy(input int c);
      foreach (win_s[i]) if (c >= win_s[i] + 1 && c <= win_e[i]) return 1'b1;
      return 1'b0;
   endfunction

   // A load accepted in cycle s: shift beams N-1..0 in s+2.., update, then done.
   task automatic schedule(input int s);
      shift_t e;
      win_s.push_back(s);
      win_e.push_back(s + N + 2);
      for (int i = 0; i < N; i++) begin
         e.cyc = s + 2 + i;
         e.dat = shadow[N-1-i];
         shift_q.push_back(e);
      end
      upd_q.push_back(s + N + 2);
      done_q.push_back(s + N + 3);
      next_done = s + N + 3;
   endtask

   task automatic model(input int c, input bit rst, input bit we, input logic [7:0] a,
                        input logic [DW-1:0] d, input bit ld);
      bit busy;
      if (rst) begin
         while (shift_q.size() > 0 && shift_q[$].cyc > c) void'(shift_q.pop_back());
         while (upd_q.size() > 0 && upd_q[$] > c) void'(upd_q.pop_back());
         while (done_q.size() > 0 && done_q[$] > c) void'(done_q.pop_back());
         while (err_q.size() > 0 && err_q[$] > c) void'(err_q.pop_back());
         foreach (win_e[i]) if (win_e[i] > c) win_e[i] = c;
         pending = 1'b0;
         next_done = -1;
         return;
      end
      busy = model_busy(c);
      if (we) begin
         if (busy || a >= N) err_q.push_back(c + 1);
         else shadow[a] = d;
      end
      if (c == next_done) begin
         if (pending || ld) begin
            pending = 1'b0;
            schedule(c);
         end
      end else if (ld) begin
         if (busy) pending = 1'b1;
         else schedule(c);
      end
   endtask

   task automatic step(input bit rst, input bit we, input logic [7:0] a,
                       input logic [DW-1:0] d, input bit ld);
      rstn_i     = !rst;
      thr_we_i   = we;
      thr_addr_i = a;
      thr_dat_i  = d;
      load_req_i = ld;
      model(cyc, rst, we, a, d, ld);
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, '0, 1'b0);
   endtask

   // Monitor
   logic [1:0]    m_wr;
   logic [1:0]    m_upd;
   logic [DW-1:0] m_dat;
   logic          m_done;
   logic          m_err;

   always @(negedge clk_i) begin
      if (mon_en) begin
         m_wr = 2'b00; m_dat = '0; m_upd = 2'b00; m_done = 1'b0; m_err = 1'b0;
         if (shift_q.size() > 0 && shift_q[0].cyc == cyc) begin
            m_wr  = 2'b11;
            m_dat = shift_q[0].dat;
            void'(shift_q.pop_front());
         end
         if (upd_q.size() > 0 && upd_q[0] == cyc) begin
            m_upd = 2'b11;
            void'(upd_q.pop_front());
         end
         if (done_q.size() > 0 && done_q[0] == cyc) begin
            m_done = 1'b1;
            void'(done_q.pop_front());
         end
         if (err_q.size() > 0 && err_q[0] == cyc) begin
            m_err = 1'b1;
            void'(err_q.pop_front());
         end
         chk("thresh_wr_o", thresh_wr_o, m_wr);
         chk("thresh_o", thresh_o, m_dat);
         chk("thresh_update_o", thresh_update_o, m_upd);
         chk("done_o", done_o, m_done);
         chk("wr_err_o", wr_err_o, m_err);
         chk("busy_o", busy_o, model_busy(cyc));
      end
   end

   bit            r_rst, r_we, r_ld;
   logic [7:0]    r_addr;
   logic [63:0]   r_val;

   initial begin
      for (int i = 0; i < N; i++) shadow[i] = {DEF, DEF};
      repeat (3) step(1'b1, 1'b0, 8'd0, '0, 1'b0);
      mon_en = 1'b1;
      idle(2);

      // Default contents after power-up
      step(1'b0, 1'b0, 8'd0, '0, 1'b1);
      idle(9);

      // Beam 3 must come out first, beam 0 last
      step(1'b0, 1'b1, 8'd3, {18'd100, 18'd200}, 1'b0);
      step(1'b0, 1'b1, 8'd0, {18'd5, 18'd6}, 1'b0);
      step(1'b0, 1'b0, 8'd0, '0, 1'b1);
      idle(9);

      // Dropped writes: out of range and during busy
      step(1'b0, 1'b1, 8'(N), {18'd1, 18'd1}, 1'b0);
      step(1'b0, 1'b1, 8'hff, {18'd2, 18'd2}, 1'b0);
      step(1'b0, 1'b0, 8'd0, '0, 1'b1);
      step(1'b0, 1'b0, 8'd0, '0, 1'b0);
      step(1'b0, 1'b1, 8'd1, {18'd3, 18'd3}, 1'b0);
      step(1'b0, 1'b1, 8'd2, {18'd4, 18'd4}, 1'b0);
      idle(8);
      step(1'b0, 1'b0, 8'd0, '0, 1'b1);
      idle(9);

      // Write coincident with the load request
      step(1'b0, 1'b1, 8'd2, {18'd777, 18'd888}, 1'b1);
      idle(9);

      // Three requests while busy collapse to one back-to-back load
      step(1'b0, 1'b0, 8'd0, '0, 1'b1);
      idle(1);
      step(1'b0, 1'b0, 8'd0, '0, 1'b1);
      step(1'b0, 1'b0, 8'd0, '0, 1'b1);
      idle(1);
      step(1'b0, 1'b0, 8'd0, '0, 1'b1);
      idle(20);

      // Reset at shift index 1 aborts with no update; shadow survives
      step(1'b0, 1'b1, 8'd1, {18'd11, 18'd22}, 1'b0);
      step(1'b0, 1'b1, 8'd2, {18'd33, 18'd44}, 1'b0);
      step(1'b0, 1'b0, 8'd0, '0, 1'b1);
      idle(3);
      step(1'b1, 1'b0, 8'd0, '0, 1'b0);
      idle(2);
      step(1'b0, 1'b0, 8'd0, '0, 1'b1);
      idle(9);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         r_rst  = ($urandom_range(0, 149) == 0);
         r_we   = ($urandom_range(0, 2) == 0);
         r_ld   = ($urandom_range(0, 9) == 0);
         r_addr = 8'($urandom_range(0, 5));
         r_val  = {$urandom(), $urandom()};
         step(r_rst, r_we, r_addr, r_val[DW-1:0], r_ld);
      end
      idle(20);

      chk("shift_events_drained", 64'(shift_q.size()), 64'd0);
      chk("update_events_drained", 64'(upd_q.size()), 64'd0);
      chk("done_events_drained", 64'(done_q.size()), 64'd0);
      chk("err_events_drained", 64'(err_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/beam_threshold_loader.md
BEAM_THRESHOLD_LOADER -- requirements
Module: beam_threshold_loader

Interface
REQ-001 Parameter NBEAMS, default 48: number of beams in the threshold cascade; even, 2..128.
REQ-002 Parameter TBITS, default 18: width of one threshold.
REQ-003 Parameter DEFAULT_THRESH, default 18'd4000: power-up value of every shadow entry.
REQ-004 clk_i  in  1  the only clock.
REQ-005 rstn_i  in  1  reset, synchronous to clk_i, active-low.
REQ-006 thr_addr_i  in  8  beam index for a shadow write.
REQ-007 thr_dat_i  in  2*TBITS  {subthreshold, threshold} for that beam.
REQ-008 thr_we_i  in  1  shadow write strobe, one write per cycle.
REQ-009 load_req_i  in  1  single-cycle request to push all shadow entries into the cascade.
REQ-010 busy_o  out  1  high from load acceptance until done_o.
REQ-011 done_o  out  1  one-cycle pulse when a load completes.
REQ-012 wr_err_o  out  1  one-cycle pulse when a shadow write is dropped.
REQ-013 thresh_o  out  2*TBITS  threshold pair driven into the beamformer cascade.
REQ-014 thresh_wr_o  out  2  per-threshold shift-in strobe; bit0 = threshold, bit1 = subthreshold.
REQ-015 thresh_update_o  out  2  per-threshold commit strobe; same bit mapping.

Function
REQ-016 The shadow store SHALL hold NBEAMS entries of 2*TBITS bits, 1-cycle read latency, initialised to {DEFAULT_THRESH, DEFAULT_THRESH}.
REQ-017 In IDLE, thr_we_i with thr_addr_i < NBEAMS SHALL write thr_dat_i to entry thr_addr_i at the next edge.
REQ-018 thr_we_i with thr_addr_i >= NBEAMS, or any thr_we_i while busy_o=1, SHALL be dropped and SHALL pulse wr_err_o on the following cycle.
REQ-019 The FSM SHALL have the states IDLE, PREFETCH, SHIFT, UPDATE and DONE.
REQ-020 IDLE->PREFETCH on load_req_i; busy_o SHALL rise the cycle after the request (cycle 1).
REQ-021 PREFETCH SHALL issue a read of entry NBEAMS-1 and last one cycle.
REQ-022 SHIFT SHALL last exactly NBEAMS cycles (cycles 2..NBEAMS+1); each cycle it SHALL drive thresh_wr_o=2'b11 and thresh_o=entry k, k descending NBEAMS-1..0, with no gaps.
REQ-023 Beam 0's entry SHALL be the last shifted, so the first-written entry lands at the far end of the cascade.
REQ-024 UPDATE SHALL last one cycle (cycle NBEAMS+2), drive thresh_update_o=2'b11 and thresh_wr_o=2'b00.
REQ-025 DONE SHALL last one cycle (cycle NBEAMS+3), pulse done_o and deassert busy_o; the FSM SHALL then return to IDLE.
REQ-026 Outside SHIFT, thresh_wr_o SHALL be 2'b00; outside UPDATE, thresh_update_o SHALL be 2'b00.
REQ-027 Outside SHIFT, thresh_o SHALL be zero.
REQ-028 A load_req_i while busy_o=1 SHALL set a single pending flag; multiple requests collapse into that one flag.
REQ-029 When the pending flag is set at DONE, the FSM SHALL go directly to PREFETCH and clear the flag.
REQ-030 A thr_we_i coincident with load_req_i in IDLE SHALL be written, and the load SHALL see the new value.
REQ-031 The beam-index counter SHALL be $clog2(NBEAMS) bits and SHALL not wrap: the SHIFT exit is at index 0.

Reset
REQ-032 While rstn_i=0 at an edge, the following SHALL apply: state=IDLE, pending=0, busy_o=0, done_o=0, wr_err_o=0, thresh_o=0, thresh_wr_o=0, thresh_update_o=0.
REQ-033 Reset SHALL NOT alter shadow contents.
REQ-034 Reset mid-load SHALL abort without issuing thresh_update_o, so the beamformer keeps its previously committed thresholds.

Structure
REQ-035 The FSM state enum and DEFAULT_THRESH SHALL live in the shared beam package next to NUM_BEAM, so the default NBEAMS can equal NUM_BEAM.
REQ-036 The shadow store SHALL be one sub-module, threshold_shadow_ram: a simple dual-port RAM with 1-cycle read and no reset.

Verification
REQ-037 Reset, then load_req_i with NBEAMS=4 -> 4 wr cycles carrying DEFAULT_THRESH pairs at cycles 2-5, update 2'b11 at cycle 6, done_o at cycle 7.
REQ-038 Write addr 3={18'd100,18'd200} and addr 0={18'd5,18'd6} with NBEAMS=4, then load -> thresh_o sequence {100,200},{DEF,DEF},{DEF,DEF},{5,6}.
REQ-039 Write addr=NBEAMS, and a write during busy -> wr_err_o pulse each time; a subsequent load shows unchanged entries.
REQ-040 Three load_req_i during busy -> exactly one extra load with no idle cycle between done_o and the next PREFETCH; exactly 2 update pulses total.
REQ-041 Assert rstn_i=0 at SHIFT index 1 -> no update pulse, all outputs 0 next cycle; a following load reproduces the pre-reset shadow values.
